shift_unit_seq: RTL and testbench



---
 rtl/mips_pkg.sv | 11 +
 rtl/shift_step.sv | 17 +
 rtl/shift_unit_seq.sv | 104 ++++++++++
 tb/tb_shift_unit_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared shift-unit op encodings, FSM state type and shift-amount width
package mips_pkg;
    localparam int SHAMT_W = 5;
    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-bit shift of a value for the given shift op
module shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    import mips_pkg::*;
    // single-position shift; non-shift ops pass the value through
    always_comb begin
        q = op == SH_SLL ? {d[WIDTH-2:0], 1'b0} :
            op == SH_SRL ? {1'b0, d[WIDTH-1:1]} :
            op == SH_SRA ? {d[WIDTH-1], d[WIDTH-1:1]} :
            op == SH_ROR ? {d[0], d[WIDTH-1:1]} : d;
    end
endmodule

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: iterative MIPS shift unit, one bit per clock; define SHIFT_UNIT_BARREL_EN for single-cycle barrel shifting
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [15:0]      shamt_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);
    import mips_pkg::*;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [SHAMT_W-1:0] sh;
    logic               is_shift;
    logic               unused_shamt;
    assign sh           = shamt_in[SHAMT_W-1:0];
    assign unused_shamt = ^shamt_in[15:SHAMT_W];
    assign is_shift     = op inside {SH_SLL, SH_SRL, SH_SRA, SH_ROR};
`ifdef SHIFT_UNIT_BARREL_EN
    logic [WIDTH-1:0] sra_v, barrel;
    assign sra_v = $signed(data_in) >>> sh;
    // full shift result computed from the live inputs at acceptance
    always_comb begin
        barrel = op == SH_SLL ? data_in << sh :
                 op == SH_SRL ? data_in >> sh :
                 op == SH_SRA ? sra_v :
                 op == SH_ROR ? (data_in >> sh) | (data_in << (WIDTH - int'(sh))) : data_in;
    end
`else
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   step;
    shift_step #(.WIDTH(WIDTH)) u_step (.op(op_q), .d(data_q), .q(step));
`endif
    // next-state, result and status computation; busy/done follow the next state so they are registered
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
`ifndef SHIFT_UNIT_BARREL_EN
        cnt_d   = cnt_q;
        op_d    = op_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && op == SH_LOAD) begin
                    data_d  = data_in;
                    state_d = ST_DONE;
                end else if (start && is_shift) begin
`ifdef SHIFT_UNIT_BARREL_EN
                    data_d  = barrel;
                    state_d = ST_DONE;
`else
                    data_d  = data_in;
                    cnt_d   = sh;
                    op_d    = op;
                    state_d = sh == '0 ? ST_DONE : ST_SHIFT;
`endif
                end
            end
`ifndef SHIFT_UNIT_BARREL_EN
            ST_SHIFT: begin
                data_d  = step;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == SHAMT_W'(1) ? ST_DONE : ST_SHIFT;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE;
        done_d = state_d == ST_DONE;
    end
    // state and result registers; reset abandons any shift in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifndef SHIFT_UNIT_BARREL_EN
            cnt_q   <= '0;
            op_q    <= SH_NOP;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifndef SHIFT_UNIT_BARREL_EN
            cnt_q   <= cnt_d;
            op_q    <= op_d;
`endif
        end
    end
    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: table-driven and sequence checks of shift_unit_seq
module tb_shift_unit_seq;
    import mips_pkg::*;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = SH_NOP;
    logic [31:0] data_in = '0;
    logic [15:0] shamt_in = '0;
    logic [31:0] data_out;
    logic        busy, done;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d;
        logic [15:0] s;
        logic [31:0] exp_d;
        int          exp_lat;
    } vec_t;

    shift_unit_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .data_in(data_in), .shamt_in(shamt_in),
        .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // issue one op from IDLE (called at posedge+1) and follow it to completion
    task automatic run(input vec_t v, input string name);
        int lat;
        int exp_lat;
        exp_lat = v.exp_lat;
`ifdef SHIFT_UNIT_BARREL_EN
        exp_lat = 1;
`endif
        start = 1'b1; op = v.op; data_in = v.d; shamt_in = v.s;
        @(posedge clk); #1;
        start = 1'b0; op = SH_SLL; data_in = ~v.d; shamt_in = ~v.s;
        chk({name, " busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " data"}, data_out, v.exp_d);
        @(posedge clk); #1;
        chk({name, " done pulse"}, 32'(done), 32'd0);
        chk({name, " idle"}, 32'(busy), 32'd0);
        chk({name, " hold"}, data_out, v.exp_d);
    endtask

    initial begin
        vec_t vecs[10];
        int   lat;
        bit   saw_done;
        vecs[0] = '{SH_LOAD, 32'hDEADBEEF, 16'h0000, 32'hDEADBEEF, 1};
        vecs[1] = '{SH_SRA,  32'h80000010, 16'h0004, 32'hF8000001, 5};
        vecs[2] = '{SH_ROR,  32'h00000001, 16'hFFE1, 32'h80000000, 2};
        vecs[3] = '{SH_SLL,  32'h12345678, 16'h0000, 32'h12345678, 1};
        vecs[4] = '{SH_SRL,  32'hF0000000, 16'h0004, 32'h0F000000, 5};
        vecs[5] = '{SH_SLL,  32'h00000001, 16'h001F, 32'h80000000, 32};
        vecs[6] = '{SH_SRA,  32'h7FFFFFFF, 16'h001F, 32'h00000000, 32};
        vecs[7] = '{SH_ROR,  32'h12345678, 16'h0008, 32'h78123456, 9};
        vecs[8] = '{SH_SRL,  32'h80000000, 16'hFFFF, 32'h00000001, 32};
        vecs[9] = '{SH_SLL,  32'hA5A5A5A5, 16'h0004, 32'h5A5A5A50, 5};

        start = 1'b1; op = SH_LOAD; data_in = 32'hFFFFFFFF;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data", data_out, 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        op = SH_NOP;
        reset_n = 1'b1;
        foreach (vecs[i]) if (i < 3) begin
            op = i == 0 ? SH_NOP : (i == 1 ? 3'b110 : 3'b111);
            @(posedge clk); #1;
            chk($sformatf("nop%0d busy", i), 32'(busy), 32'd0);
            chk($sformatf("nop%0d done", i), 32'(done), 32'd0);
            chk($sformatf("nop%0d data", i), data_out, 32'h0);
        end
        start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run(vecs[i], $sformatf("vec%0d", i));

        start = 1'b1; op = SH_SRL; data_in = 32'h80000000; shamt_in = 16'h001F;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 64) begin
            if (lat == 3) begin
                start = 1'b1; op = SH_LOAD; data_in = 32'h11111111;
            end else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
`ifdef SHIFT_UNIT_BARREL_EN
        chk("busy-start latency", lat, 1);
`else
        chk("busy-start latency", lat, 32);
`endif
        chk("busy-start data", data_out, 32'h00000001);
        @(posedge clk); #1;
        chk("busy-start not queued", 32'(busy), 32'd0);

`ifndef SHIFT_UNIT_BARREL_EN
        start = 1'b1; op = SH_SLL; data_in = 32'h00000001; shamt_in = 16'h0008;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midshift partial", data_out, 32'h00000008);
        reset_n = 1'b0;
        #1;
        chk("midshift reset data", data_out, 32'h0);
        chk("midshift reset busy", 32'(busy), 32'd0);
        chk("midshift reset done", 32'(done), 32'd0);
        #2 reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("midshift no done", 32'(saw_done), 32'd0);
        chk("midshift idle", 32'(busy), 32'd0);
`else
        saw_done = 1'b0;
        run('{SH_SLL, 32'h00000001, 16'h0008, 32'h00000100, 1}, "barrel sll8");
`endif
        run('{SH_LOAD, 32'hCAFEF00D, 16'h001F, 32'hCAFEF00D, 1}, "post-reset load");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
